// File: rtl/paddle_input_stage.sv
// Per-player input conditioner: delay pipe, playfield clamp, frame-latched outputs at vblank start.
// Optional PADDLE_SLEW_EN limits per-frame paddle movement to MAX_STEP after the first latch.

module paddle_input_chan #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 2,
    parameter int MAX_POS = 767
`ifdef PADDLE_SLEW_EN
    ,
    parameter int MAX_STEP = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pos,
    input  logic             i_btn,
    input  logic             i_latch,
`ifdef PADDLE_SLEW_EN
    input  logic             i_valid,
`endif
    output logic [WIDTH-1:0] o_pos,
    output logic             o_btn,
    output logic             o_press
);
    localparam logic [WIDTH-1:0] LP_MAX_POS = WIDTH'(MAX_POS);

    logic [DEPTH-1:0][WIDTH-1:0] r_pos_pipe;
    logic [DEPTH-1:0]            r_btn_pipe;
    logic [WIDTH-1:0]            r_pos;
    logic                        r_btn;
    logic                        r_press;
    logic [WIDTH-1:0]            w_tap;
    logic [WIDTH-1:0]            w_target;
    logic [WIDTH-1:0]            w_next;

    assign w_tap    = r_pos_pipe[DEPTH-1];
    assign w_target = (w_tap > LP_MAX_POS) ? LP_MAX_POS : w_tap;

`ifdef PADDLE_SLEW_EN
    localparam logic signed [WIDTH:0] LP_STEP = (WIDTH+1)'(MAX_STEP);
    logic signed [WIDTH:0] w_diff;

    // Both operands zero-extended, so the signed difference cannot overflow.
    assign w_diff = $signed({1'b0, w_target}) - $signed({1'b0, r_pos});

    always_comb begin
        w_next = w_target;
        if (i_valid) begin
            if (w_diff > LP_STEP)
                w_next = r_pos + WIDTH'(MAX_STEP);
            else if (w_diff < -LP_STEP)
                w_next = r_pos - WIDTH'(MAX_STEP);
        end
    end
`else
    assign w_next = w_target;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos_pipe <= '0;
            r_btn_pipe <= '0;
            r_pos      <= '0;
            r_btn      <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_pos_pipe[0] <= i_pos;
            r_btn_pipe[0] <= i_btn;
            for (int i = 1; i < DEPTH; i++) begin
                r_pos_pipe[i] <= r_pos_pipe[i-1];
                r_btn_pipe[i] <= r_btn_pipe[i-1];
            end
            r_press <= 1'b0;
            if (i_latch) begin
                r_pos   <= w_next;
                r_btn   <= r_btn_pipe[DEPTH-1];
                r_press <= r_btn_pipe[DEPTH-1] & ~r_btn;
            end
        end
    end

    assign o_pos   = r_pos;
    assign o_btn   = r_btn;
    assign o_press = r_press;
endmodule

module paddle_input_stage #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 2,
    parameter int MAX_POS  = 767,
    parameter int MAX_STEP = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_pos_in,
    input  logic [CHANNELS-1:0]       i_btn_in,
    input  logic                      i_vblnk_in,
    output logic [CHANNELS*WIDTH-1:0] o_pos_out,
    output logic [CHANNELS-1:0]       o_btn_out,
    output logic [CHANNELS-1:0]       o_btn_press,
    output logic                      o_frame_tick,
    output logic                      o_valid
);
    if (CHANNELS < 1 || DEPTH < 1 || MAX_STEP < 1) begin : g_param_err
        $error("paddle_input_stage: CHANNELS, DEPTH and MAX_STEP must be >= 1");
    end

    logic r_vblnk_prev;
    logic r_frame_tick;
    logic r_valid;
    logic w_latch;

    assign w_latch = i_vblnk_in & ~r_vblnk_prev;

    // vblnk_prev resets high so a vblank already in progress at release is not latched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vblnk_prev <= 1'b1;
            r_frame_tick <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_vblnk_prev <= i_vblnk_in;
            r_frame_tick <= w_latch;
            r_valid      <= r_valid | w_latch;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        paddle_input_chan #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .MAX_POS (MAX_POS)
`ifdef PADDLE_SLEW_EN
            ,
            .MAX_STEP(MAX_STEP)
`endif
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_pos   (i_pos_in[c*WIDTH +: WIDTH]),
            .i_btn   (i_btn_in[c]),
            .i_latch (w_latch),
`ifdef PADDLE_SLEW_EN
            .i_valid (r_valid),
`endif
            .o_pos   (o_pos_out[c*WIDTH +: WIDTH]),
            .o_btn   (o_btn_out[c]),
            .o_press (o_btn_press[c])
        );
    end

    assign o_frame_tick = r_frame_tick;
    assign o_valid      = r_valid;
endmodule

// File: tb/tb_paddle_input_stage.sv
// Randomized + directed bench for paddle_input_stage against a frame-level reference model.
// Honours PADDLE_SLEW_EN the same way as the design build.

module tb_paddle_input_stage;
    localparam int CH   = 2;
    localparam int W    = 12;
    localparam int D    = 2;
    localparam int MAXP = 767;
    localparam int STEP = 16;
`ifdef PADDLE_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH*W-1:0] pos_in;
    logic [CH-1:0] btn_in;
    logic          vblnk;
    logic [CH*W-1:0] pos_out;
    logic [CH-1:0] btn_out;
    logic [CH-1:0] btn_press;
    logic          frame_tick;
    logic          valid;

    paddle_input_stage #(
        .CHANNELS(CH), .WIDTH(W), .DEPTH(D), .MAX_POS(MAXP), .MAX_STEP(STEP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pos_in    (pos_in),
        .i_btn_in    (btn_in),
        .i_vblnk_in  (vblnk),
        .o_pos_out   (pos_out),
        .o_btn_out   (btn_out),
        .o_btn_press (btn_press),
        .o_frame_tick(frame_tick),
        .o_valid     (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] p1;
        logic [W-1:0] p0;
        logic [1:0]   b;
    } samp_t;

    samp_t q[$];
    int    m_pos[CH];
    bit    m_btn[CH];
    bit    m_press[CH];
    bit    m_tick, m_valid, m_vprev;
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < D; i++) q.push_back('0);
        for (int c = 0; c < CH; c++) begin
            m_pos[c] = 0; m_btn[c] = 0; m_press[c] = 0;
        end
        m_tick = 0; m_valid = 0; m_vprev = 1;
    endtask

    // One rising edge: the latch sees the oldest queued sample, then the new sample enters.
    task automatic model_step();
        samp_t tap;
        bit    latch;
        int    tp, tgt;
        bit    tb;
        tap   = q[0];
        latch = vblnk && !m_vprev;
        m_vprev = vblnk;
        m_tick  = latch;
        for (int c = 0; c < CH; c++) begin
            m_press[c] = 0;
            if (latch) begin
                tp  = (c == 0) ? int'(tap.p0) : int'(tap.p1);
                tb  = tap.b[c];
                tgt = (tp > MAXP) ? MAXP : tp;
                if (SLEW && m_valid) begin
                    if (tgt - m_pos[c] > STEP)       m_pos[c] = m_pos[c] + STEP;
                    else if (tgt - m_pos[c] < -STEP) m_pos[c] = m_pos[c] - STEP;
                    else                             m_pos[c] = tgt;
                end else begin
                    m_pos[c] = tgt;
                end
                m_press[c] = tb & ~m_btn[c];
                m_btn[c]   = tb;
            end
        end
        m_valid = m_valid | latch;
        q.push_back({pos_in[2*W-1:W], pos_in[W-1:0], btn_in});
        void'(q.pop_front());
    endtask

    task automatic check_all();
        chk("pos0",   pos_out[W-1:0],   m_pos[0]);
        chk("pos1",   pos_out[2*W-1:W], m_pos[1]);
        chk("btn0",   btn_out[0],       m_btn[0]);
        chk("btn1",   btn_out[1],       m_btn[1]);
        chk("press0", btn_press[0],     m_press[0]);
        chk("press1", btn_press[1],     m_press[1]);
        chk("tick",   frame_tick,       m_tick);
        chk("valid",  valid,            m_valid);
    endtask

    task automatic step_cyc(input int p0, input int p1, input logic [1:0] b, input logic vb);
        @(negedge clk);
        pos_in = {p1[W-1:0], p0[W-1:0]};
        btn_in = b;
        vblnk  = vb;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic frame(input int p0, input int p1, input logic [1:0] b, input int lo, input int hi);
        repeat (lo) step_cyc(p0, p1, b, 1'b0);
        repeat (hi) step_cyc(p0, p1, b, 1'b1);
    endtask

    // Reset asserted mid-cycle; released while vblnk is at vb_rel.
    task automatic do_reset(input logic vb_rel);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        vblnk = vb_rel;
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    initial begin
        int p0, p1, lo, hi;
        logic [1:0] b;

        rst_n = 1'b0; pos_in = '0; btn_in = '0; vblnk = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // First latch
        frame(300, 0, 2'b00, 4, 3);
        chk("first_latch_pos", pos_out[W-1:0], 300);
        chk("first_latch_valid", valid, 1);

        // Slew toward 400
        frame(400, 0, 2'b00, 4, 2);
        chk("slew_f1", pos_out[W-1:0], SLEW ? 316 : 400);
        repeat (3) frame(400, 0, 2'b00, 4, 2);
        chk("slew_f4", pos_out[W-1:0], SLEW ? 364 : 400);

        // Clamp ch1 and step back down
        repeat (50) frame(400, 4000, 2'b00, 3, 2);
        chk("clamp_max", pos_out[2*W-1:W], 767);
        frame(400, 0, 2'b00, 3, 2);
        chk("clamp_down", pos_out[2*W-1:W], SLEW ? 751 : 0);

        // Short button blip between latches is invisible
        repeat (3) step_cyc(400, 0, 2'b00, 1'b0);
        step_cyc(400, 0, 2'b10, 1'b0);
        repeat (3) step_cyc(400, 0, 2'b00, 1'b0);
        repeat (2) step_cyc(400, 0, 2'b00, 1'b1);
        chk("blip_btn", btn_out[1], 0);

        // Held button: press pulses with frame_tick, once
        repeat (3) step_cyc(400, 0, 2'b10, 1'b0);
        step_cyc(400, 0, 2'b10, 1'b1);
        chk("press_hi", btn_press[1], 1);
        chk("press_tick", frame_tick, 1);
        step_cyc(400, 0, 2'b10, 1'b1);
        chk("press_1cyc", btn_press[1], 0);
        frame(400, 0, 2'b10, 3, 1);
        chk("held_btn", btn_out[1], 1);
        chk("held_no_press", btn_press[1], 0);

        // Latency: change one cycle before vblank rise is not seen by that latch
        repeat (10) frame(300, 0, 2'b00, 3, 2);
        repeat (3) step_cyc(300, 0, 2'b00, 1'b0);
        step_cyc(350, 0, 2'b00, 1'b0);
        step_cyc(350, 0, 2'b00, 1'b1);
        chk("lat_keep", pos_out[W-1:0], 300);
        frame(350, 0, 2'b00, 3, 2);
        chk("lat_next", pos_out[W-1:0], SLEW ? 316 : 350);

        // Reset mid-frame with vblank high at release: no latch until it re-rises
        step_cyc(500, 100, 2'b11, 1'b0);
        do_reset(1'b1);
        repeat (4) step_cyc(500, 100, 2'b11, 1'b1);
        chk("rst_no_tick", valid, 0);
        frame(500, 100, 2'b11, 3, 2);
        chk("rst_relatch", valid, 1);

        // Randomized frames
        p0 = 0; p1 = 0; b = 2'b00;
        for (int f = 0; f < 200; f++) begin
            if (f == 100) do_reset(1'($urandom_range(0, 1)));
            lo = $urandom_range(1, 12);
            hi = $urandom_range(1, 6);
            for (int k = 0; k < lo + hi; k++) begin
                if ($urandom_range(0, 3) == 0)
                    p0 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 900);
                if ($urandom_range(0, 3) == 0)
                    p1 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 900);
                if ($urandom_range(0, 9) < 3) b = 2'($urandom_range(0, 3));
                step_cyc(p0, p1, b, (k >= lo) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
